// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access length encodings, FSM states,
// default timeout and address-offset helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        LEN_NONE = 2'b00,
        LEN_BYTE = 2'b01,
        LEN_HALF = 2'b10,
        LEN_WORD = 2'b11
    } len_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_e;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    // Low address bits actually used for lane selection once misalignment is ignored.
    function automatic logic [1:0] eff_offset(len_e len, logic [1:0] off);
        case (len)
            LEN_HALF: return {off[1], 1'b0};
            LEN_WORD: return 2'b00;
            default:  return off;
        endcase
    endfunction

    function automatic logic misaligned(len_e len, logic [1:0] off);
        return ((len == LEN_HALF) && off[0]) || ((len == LEN_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Datapath-side request/response bus and RAM-side bus of the load/store unit.
interface lsu_req_if;
    logic        LSU_req_valid;
    logic        LSU_req_ready;
    logic        LSU_req_write;
    logic [1:0]  LSU_length;
    logic        LSU_signed;
    logic [31:0] LSU_address;
    logic [31:0] LSU_write_data;
    logic        LSU_resp_valid;
    logic [31:0] LSU_read_data;
    logic        LSU_fault;

    modport master (
        output LSU_req_valid, LSU_req_write, LSU_length, LSU_signed, LSU_address, LSU_write_data,
        input  LSU_req_ready, LSU_resp_valid, LSU_read_data, LSU_fault
    );

    modport slave (
        input  LSU_req_valid, LSU_req_write, LSU_length, LSU_signed, LSU_address, LSU_write_data,
        output LSU_req_ready, LSU_resp_valid, LSU_read_data, LSU_fault
    );
endinterface

interface lsu_ram_if;
    logic        RAM_req;
    logic        RAM_we;
    logic [29:0] RAM_addr;
    logic [3:0]  RAM_byte_en;
    logic [31:0] RAM_wdata;
    logic        RAM_ack;
    logic [31:0] RAM_rdata;

    modport master (
        output RAM_req, RAM_we, RAM_addr, RAM_byte_en, RAM_wdata,
        input  RAM_ack, RAM_rdata
    );

    modport slave (
        input  RAM_req, RAM_we, RAM_addr, RAM_byte_en, RAM_wdata,
        output RAM_ack, RAM_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/data steering and load lane
// extraction with zero/sign extension.
module lsu_align
    import lsu_pkg::*;
(
    input  len_e        st_length,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    input  len_e        ld_length,
    input  logic [1:0]  ld_offset,
    input  logic        ld_signed,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        byte_en = '0;
        wdata   = '0;
        case (st_length)
            LEN_BYTE: begin
                byte_en = 4'b0001 << st_offset;
                wdata   = {4{st_data[7:0]}};
            end
            LEN_HALF: begin
                byte_en = st_offset[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{st_data[15:0]}};
            end
            LEN_WORD: begin
                byte_en = 4'b1111;
                wdata   = st_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_offset)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = ld_offset[1] ? rdata[31:16] : rdata[15:0];

        load_data = '0;
        case (ld_length)
            LEN_BYTE: load_data = {{24{ld_signed & lane_b[7]}}, lane_b};
            LEN_HALF: load_data = {{16{ld_signed & lane_h[15]}}, lane_h};
            LEN_WORD: load_data = rdata;
            default:  ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> ACCESS -> RESP sequencer between datapath and a single-port RAM.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of truncating the address.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic      SYS_clk,
    input  logic      SYS_reset,
    lsu_req_if.slave  lsu,
    lsu_ram_if.master ram
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e    state;
    logic [TW-1:0] timer;

    len_e        ld_len;
    logic [1:0]  ld_off;
    logic        ld_signed;
    logic        ld_write;

    logic        ram_req_q;
    logic        ram_we_q;
    logic [29:0] ram_addr_q;
    logic [3:0]  ram_be_q;
    logic [31:0] ram_wdata_q;
    logic        resp_valid_q;
    logic        fault_q;
    logic [31:0] read_data_q;

    len_e        req_len;
    logic [1:0]  req_off;
    logic        req_trap;
    logic [3:0]  al_byte_en;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    assign req_len = len_e'(lsu.LSU_length);
    assign req_off = eff_offset(req_len, lsu.LSU_address[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_trap = misaligned(req_len, lsu.LSU_address[1:0]);
`else
    assign req_trap = 1'b0;
`endif

    // Store steering uses the live request (registered at accept); load extraction uses latched fields.
    lsu_align u_align (
        .st_length (req_len),
        .st_offset (req_off),
        .st_data   (lsu.LSU_write_data),
        .ld_length (ld_len),
        .ld_offset (ld_off),
        .ld_signed (ld_signed),
        .rdata     (ram.RAM_rdata),
        .byte_en   (al_byte_en),
        .wdata     (al_wdata),
        .load_data (al_load)
    );

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state        <= ST_IDLE;
            timer        <= '0;
            ld_len       <= LEN_NONE;
            ld_off       <= '0;
            ld_signed    <= 1'b0;
            ld_write     <= 1'b0;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_be_q     <= '0;
            ram_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            read_data_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lsu.LSU_req_valid) begin
                        ld_len    <= req_len;
                        ld_off    <= req_off;
                        ld_signed <= lsu.LSU_signed;
                        ld_write  <= lsu.LSU_req_write;
                        if ((req_len == LEN_NONE) || req_trap) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            fault_q      <= req_trap;
                            read_data_q  <= '0;
                        end else begin
                            state       <= ST_ACCESS;
                            timer       <= '0;
                            ram_req_q   <= 1'b1;
                            ram_we_q    <= lsu.LSU_req_write;
                            ram_addr_q  <= lsu.LSU_address[31:2];
                            ram_be_q    <= al_byte_en;
                            ram_wdata_q <= al_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (ram.RAM_ack) begin
                        state        <= ST_RESP;
                        ram_req_q    <= 1'b0;
                        ram_we_q     <= 1'b0;
                        ram_be_q     <= '0;
                        resp_valid_q <= 1'b1;
                        fault_q      <= 1'b0;
                        read_data_q  <= ld_write ? '0 : al_load;
                    end else begin
                        timer <= timer + TW'(1);
                        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                            state        <= ST_RESP;
                            ram_req_q    <= 1'b0;
                            ram_we_q     <= 1'b0;
                            ram_be_q     <= '0;
                            resp_valid_q <= 1'b1;
                            fault_q      <= 1'b1;
                            read_data_q  <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    fault_q      <= 1'b0;
                    read_data_q  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign lsu.LSU_req_ready  = (state == ST_IDLE);
    assign lsu.LSU_resp_valid = resp_valid_q;
    assign lsu.LSU_fault      = fault_q;
    assign lsu.LSU_read_data  = read_data_q;

    assign ram.RAM_req     = ram_req_q;
    assign ram.RAM_we      = ram_we_q;
    assign ram.RAM_addr    = ram_addr_q;
    assign ram.RAM_byte_en = ram_be_q;
    assign ram.RAM_wdata   = ram_wdata_q;

endmodule
